// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL reconfiguration controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    localparam int SEL_W = 6;

    // Width of the one counter shared by the reset, timeout and stable phases.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reset/lock sequencer with runtime divider reconfiguration.
// Define PLL_CTRL_AUTO_RELOCK_EN to relock on lock loss in RUN instead of failing.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int               RESET_PULSE_CYCLES  = 16,
    parameter int               LOCK_TIMEOUT_CYCLES = 120000,
    parameter int               LOCK_STABLE_CYCLES  = 1024,
    parameter int               MAX_RETRY           = 3,
    parameter logic [SEL_W-1:0] IDSEL_INIT          = 6'd0,
    parameter logic [SEL_W-1:0] FBDSEL_INIT         = 6'd0,
    parameter logic [SEL_W-1:0] ODSEL_INIT          = 6'd0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cfg_req,
    input  logic [SEL_W-1:0] cfg_idsel,
    input  logic [SEL_W-1:0] cfg_fbdsel,
    input  logic [SEL_W-1:0] cfg_odsel,
    output logic             cfg_ack,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [SEL_W-1:0] pll_idsel,
    output logic [SEL_W-1:0] pll_fbdsel,
    output logic [SEL_W-1:0] pll_odsel,
    output logic             user_rst_n,
    output logic             ready,
    output logic             fail
);

    localparam int CNT_W = cnt_width(RESET_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LT_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);

    pll_state_e       r_state;
    pll_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [RTY_W-1:0] r_retry;
    logic [RTY_W-1:0] w_retry_nxt;
    logic             w_capture;
    logic             w_lock_s;

    sync_2ff u_lock_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : (r_cnt + CNT_W'(1));

    // Next-state, counter and retry bookkeeping; counter idles at zero outside timed phases.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_retry_nxt = r_retry;
        w_capture   = 1'b0;
        case (r_state)
            ST_RESET: begin
                if (r_cnt == RP_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == LT_LAST) begin
                    if (r_retry < RTY_LAST) begin
                        w_retry_nxt = r_retry + RTY_W'(1);
                        w_state_nxt = ST_RESET;
                    end else begin
                        w_state_nxt = ST_FAIL;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_cnt == LS_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_retry_nxt = {RTY_W{1'b0}};
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_RUN: begin
                // A pending request outranks a simultaneous loss of lock.
                if (cfg_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESET;
                end else if (!w_lock_s) begin
`ifdef PLL_CTRL_AUTO_RELOCK_EN
                    w_state_nxt = ST_RESET;
                    w_retry_nxt = {RTY_W{1'b0}};
`else
                    w_state_nxt = ST_FAIL;
`endif
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FAIL: begin
                if (cfg_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESET;
                    w_retry_nxt = {RTY_W{1'b0}};
                end else begin
                    w_state_nxt = ST_FAIL;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
                w_retry_nxt = {RTY_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs; outputs are decoded from the next state so they align with it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_RESET;
            r_cnt      <= {CNT_W{1'b0}};
            r_retry    <= {RTY_W{1'b0}};
            cfg_ack    <= 1'b0;
            pll_reset  <= 1'b1;
            user_rst_n <= 1'b0;
            ready      <= 1'b0;
            fail       <= 1'b0;
            pll_idsel  <= IDSEL_INIT;
            pll_fbdsel <= FBDSEL_INIT;
            pll_odsel  <= ODSEL_INIT;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_retry    <= w_retry_nxt;
            cfg_ack    <= w_capture;
            pll_reset  <= (w_state_nxt == ST_RESET) || (w_state_nxt == ST_FAIL);
            user_rst_n <= (w_state_nxt == ST_RUN);
            ready      <= (w_state_nxt == ST_RUN);
            fail       <= (w_state_nxt == ST_FAIL);
            if (w_capture) begin
                pll_idsel  <= cfg_idsel;
                pll_fbdsel <= cfg_fbdsel;
                pll_odsel  <= cfg_odsel;
            end else begin
                pll_idsel  <= pll_idsel;
                pll_fbdsel <= pll_fbdsel;
                pll_odsel  <= pll_odsel;
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed/randomized bench for pll_reconfig_ctrl; expectations come from phase-length arithmetic.
module tb_pll_reconfig_ctrl;

    localparam int RP = 4;
    localparam int LT = 32;
    localparam int LS = 8;
    localparam int MR = 2;
    localparam int SYNC_LAT = 2;
    // Edges from a pll_lock rise (while waiting for lock) to ready: synchronizer, state entry, stable window.
    localparam int LOCK_TO_READY = SYNC_LAT + 1 + LS;
    // Edges from cfg_ack to ready when lock never drops: reset pulse, one cycle to see lock, stable window.
    localparam int ACK_TO_READY = RP + 1 + LS;
    localparam int TO_FAIL = (MR + 1) * (RP + LT);
    localparam int BOUND = 1000;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cfg_req = 1'b0;
    logic [5:0] cfg_idsel = 6'd0;
    logic [5:0] cfg_fbdsel = 6'd0;
    logic [5:0] cfg_odsel = 6'd0;
    logic       pll_lock = 1'b0;
    logic       cfg_ack;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       user_rst_n;
    logic       ready;
    logic       fail;

    int         n_vec = 0;
    int         n_err = 0;
    logic [5:0] m_id = 6'd0;
    logic [5:0] m_fb = 6'd0;
    logic [5:0] m_od = 6'd0;

    always #5 sys_clk = ~sys_clk;

    pll_reconfig_ctrl #(
        .RESET_PULSE_CYCLES  (RP),
        .LOCK_TIMEOUT_CYCLES (LT),
        .LOCK_STABLE_CYCLES  (LS),
        .MAX_RETRY           (MR),
        .IDSEL_INIT          (6'd0),
        .FBDSEL_INIT         (6'd0),
        .ODSEL_INIT          (6'd0)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cfg_req    (cfg_req),
        .cfg_idsel  (cfg_idsel),
        .cfg_fbdsel (cfg_fbdsel),
        .cfg_odsel  (cfg_odsel),
        .cfg_ack    (cfg_ack),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .user_rst_n (user_rst_n),
        .ready      (ready),
        .fail       (fail)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags compared as {pll_reset, user_rst_n, cfg_ack, ready, fail}; selects against the model.
    task automatic snap(input string tag, input logic e_prst, input logic e_urst,
                        input logic e_ack, input logic e_rdy, input logic e_fail);
        chk(tag, {27'd0, pll_reset, user_rst_n, cfg_ack, ready, fail},
                 {27'd0, e_prst, e_urst, e_ack, e_rdy, e_fail});
        chk({tag, "_sel"}, {14'd0, pll_idsel, pll_fbdsel, pll_odsel}, {14'd0, m_id, m_fb, m_od});
    endtask

    function automatic logic pick(input int s);
        case (s)
            0:       return ready;
            1:       return fail;
            2:       return pll_reset;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int s, input logic v, output int n);
        n = 0;
        while (pick(s) !== v && n < BOUND) begin
            tick();
            n++;
        end
    endtask

    // Request accepted in RUN or FAIL: ack, new selects, reset asserted, then a single-cycle ack.
    task automatic req(input string tag);
        logic [5:0] a, b, c;
        a = 6'($urandom_range(63, 0));
        b = 6'($urandom_range(63, 0));
        c = 6'($urandom_range(63, 0));
        cfg_idsel = a; cfg_fbdsel = b; cfg_odsel = c;
        cfg_req = 1'b1;
        tick();
        m_id = a; m_fb = b; m_od = c;
        snap({tag, "_ack"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cfg_req = 1'b0;
        tick();
        snap({tag, "_ack_end"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n, n2, falls, d, g;
        logic acc, prev;

        // Reset values, with a request already pending that must be ignored.
        cfg_idsel = 6'd21; cfg_fbdsel = 6'd42; cfg_odsel = 6'd7; cfg_req = 1'b1;
        ticks(3);
        snap("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Power-up: reset pulse length, no ack outside RUN/FAIL, lock 10 cycles after release.
        sys_rst_n = 1'b1;
        n = 0; acc = 1'b0;
        while (pll_reset !== 1'b0 && n < BOUND) begin
            tick();
            n++;
            acc = acc | cfg_ack;
        end
        chk("pwr_reset_len", n, RP);
        chk("ignored_req_ack", {31'd0, acc}, 32'd0);
        snap("pwr_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_req = 1'b0;
        ticks(10 - RP);
        pll_lock = 1'b1;
        wait_for(0, 1'b1, n);
        chk("pwr_lock_to_ready", n, LOCK_TO_READY);
        snap("pwr_run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reconfig in RUN with fixed selects, lock held high.
        cfg_idsel = 6'd3; cfg_fbdsel = 6'd15; cfg_odsel = 6'd8; cfg_req = 1'b1;
        tick();
        m_id = 6'd3; m_fb = 6'd15; m_od = 6'd8;
        snap("rcfg_ack", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cfg_req = 1'b0;
        tick();
        chk("rcfg_ack_pulse", {31'd0, cfg_ack}, 32'd0);
        wait_for(2, 1'b0, n);
        chk("rcfg_reset_len", n + 1, RP);
        wait_for(0, 1'b1, n2);
        chk("rcfg_ack_to_ready", n + 1 + n2, ACK_TO_READY);
        snap("rcfg_run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Collision: synchronized lock loss and request seen on the same RUN cycle.
        pll_lock = 1'b0;
        ticks(SYNC_LAT);
        req("coll");
        ticks(4);
        pll_lock = 1'b1;
        wait_for(0, 1'b1, n);
        chk("coll_lock_to_ready", n, LOCK_TO_READY);
        snap("coll_run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Lock glitch at STABLE cycle 5: the stable window restarts from the re-raise.
        req("glitch");
        pll_lock = 1'b0;
        d = $urandom_range(10, 3);
        ticks(d);
        pll_lock = 1'b1;
        ticks(SYNC_LAT + 1 + 5);
        chk("glitch_not_ready", {31'd0, ready}, 32'd0);
        pll_lock = 1'b0;
        g = $urandom_range(4, 1);
        ticks(g);
        pll_lock = 1'b1;
        wait_for(0, 1'b1, n);
        chk("glitch_lock_to_ready", n, LOCK_TO_READY);
        snap("glitch_run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Plain lock loss in RUN.
        pll_lock = 1'b0;
        ticks(SYNC_LAT);
        snap("loss_pre", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
`ifdef PLL_CTRL_AUTO_RELOCK_EN
        snap("loss_relock", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(4);
        pll_lock = 1'b1;
        wait_for(0, 1'b1, n);
        chk("loss_lock_to_ready", n, LOCK_TO_READY);
`else
        snap("loss_fail", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(5);
        snap("loss_fail_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        req("loss_rcv");
        ticks(4);
        pll_lock = 1'b1;
        wait_for(0, 1'b1, n);
        chk("loss_rcv_to_ready", n, LOCK_TO_READY);
`endif
        snap("loss_run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-run returns every output at once.
        #3;
        sys_rst_n = 1'b0;
        pll_lock = 1'b0;
        #1;
        m_id = 6'd0; m_fb = 6'd0; m_od = 6'd0;
        snap("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        sys_rst_n = 1'b1;

        // Timeout: initial pulse plus MR retries, then FAIL.
        n = 0; falls = 0;
        while (fail !== 1'b1 && n < BOUND) begin
            prev = pll_reset;
            tick();
            n++;
            if (prev === 1'b1 && pll_reset === 1'b0) falls++;
        end
        chk("to_edges_to_fail", n, TO_FAIL);
        chk("to_reset_pulses", falls, MR + 1);
        snap("to_fail", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(7);
        snap("to_fail_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        req("to_rcv");
        wait_for(2, 1'b0, n);
        chk("to_rcv_reset_len", n + 1, RP);
        ticks(3);
        pll_lock = 1'b1;
        wait_for(0, 1'b1, n);
        chk("to_rcv_lock_to_ready", n, LOCK_TO_READY);
        snap("to_rcv_run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
